dmem_port_arbiter: RTL and testbench

- Shares one byte-wide, 256-byte synchronous data RAM between two word-access requesters: port 0 is the CPU load/store path and port 1 is the debug/DMA loader.
- Arbitrates between the ports, then serialises each 32-bit word access into four byte cycles, big-endian: byte 0 = bits 31:24.
- Sits between the requesters and the byte RAM macro.

---
 rtl/dmem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-port word-access arbiter in front of a byte-wide synchronous RAM.
// Each 32-bit access is serialised into four big-endian byte cycles.
module dmem_port_arbiter #(
    parameter int MEM_BYTES = 256,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_valid,
    input  logic          p0_write,
    input  logic [31:0]   p0_addr,
    input  logic [31:0]   p0_wdata,
    output logic          p0_ready,
    output logic          p0_resp,
    input  logic          p1_valid,
    input  logic          p1_write,
    input  logic [31:0]   p1_addr,
    input  logic [31:0]   p1_wdata,
    output logic          p1_ready,
    output logic          p1_resp,
    output logic [31:0]   resp_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [7:0]    mem_rdata
);

    typedef enum logic [1:0] {IDLE, XFER, TAIL, RESP} state_t;

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          port_q, port_d;
    logic          write_q, write_d;
    logic [AW-3:0] word_q, word_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [23:0]   shadow_q, shadow_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          last_grant_q, last_grant_d;
    logic          p0_resp_q, p0_resp_d;
    logic          p1_resp_q, p1_resp_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;
    logic          mem_we_q, mem_we_d;
    logic          mem_re_q, mem_re_d;

    logic idle;
    logic grant_p1;
    logic unused_addr_bits;

    // Word-address bits above the RAM size are dropped, so accesses wrap.
    assign unused_addr_bits = ^{p0_addr[31:AW-2], p1_addr[31:AW-2]};

    // Ready is gated by rst_n so every output reads 0 while reset is held.
    assign idle     = rst_n && (state_q == IDLE);
    assign grant_p1 = p1_valid && (!p0_valid || !last_grant_q);
    assign p0_ready = idle && p0_valid && !grant_p1;
    assign p1_ready = idle && grant_p1;

    assign p0_resp    = p0_resp_q;
    assign p1_resp    = p1_resp_q;
    assign resp_rdata = rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign mem_re     = mem_re_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        port_d       = port_q;
        write_d      = write_q;
        word_d       = word_q;
        wdata_d      = wdata_q;
        shadow_d     = shadow_q;
        rdata_d      = rdata_q;
        last_grant_d = last_grant_q;
        p0_resp_d    = 1'b0;
        p1_resp_d    = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (p0_ready || p1_ready) begin
                    port_d       = grant_p1;
                    last_grant_d = grant_p1;
                    write_d      = grant_p1 ? p1_write : p0_write;
                    word_d       = grant_p1 ? p1_addr[AW-3:0] : p0_addr[AW-3:0];
                    wdata_d      = grant_p1 ? p1_wdata : p0_wdata;
                    cnt_d        = 2'd0;
                    state_d      = XFER;
                end
            end
            XFER: begin
                // RAM read data lags mem_re by one cycle: byte cnt-1 arrives now.
                if (!write_q) begin
                    case (cnt_q)
                        2'd1:    shadow_d[23:16] = mem_rdata;
                        2'd2:    shadow_d[15:8]  = mem_rdata;
                        2'd3:    shadow_d[7:0]   = mem_rdata;
                        default: shadow_d        = shadow_q;
                    endcase
                end
                if (cnt_q == 2'd3) begin
                    state_d = write_q ? RESP : TAIL;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            TAIL: begin
                rdata_d = {shadow_q, mem_rdata};
                state_d = RESP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered: decode them from the next-state values.
        if (state_d == XFER) begin
            mem_addr_d = {word_d, cnt_d};
            if (write_d) begin
                mem_we_d = 1'b1;
                case (cnt_d)
                    2'd0:    mem_wdata_d = wdata_d[31:24];
                    2'd1:    mem_wdata_d = wdata_d[23:16];
                    2'd2:    mem_wdata_d = wdata_d[15:8];
                    default: mem_wdata_d = wdata_d[7:0];
                endcase
            end else begin
                mem_re_d = 1'b1;
            end
        end
        if (state_d == RESP) begin
            p0_resp_d = !port_d;
            p1_resp_d = port_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            port_q       <= 1'b0;
            write_q      <= 1'b0;
            word_q       <= '0;
            wdata_q      <= '0;
            shadow_q     <= '0;
            rdata_q      <= '0;
            last_grant_q <= 1'b1;
            p0_resp_q    <= 1'b0;
            p1_resp_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            port_q       <= port_d;
            write_q      <= write_d;
            word_q       <= word_d;
            wdata_q      <= wdata_d;
            shadow_q     <= shadow_d;
            rdata_q      <= rdata_d;
            last_grant_q <= last_grant_d;
            p0_resp_q    <= p0_resp_d;
            p1_resp_q    <= p1_resp_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural 256-byte RAM.
// Preloaded RAM holds ram[i] = i so untouched bytes are predictable.
module tb_dmem_port_arbiter;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p0_valid = 0, p0_write = 0, p1_valid = 0, p1_write = 0;
    logic [31:0]   p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
    logic          p0_ready, p0_resp, p1_ready, p1_resp;
    logic [31:0]   resp_rdata;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we, mem_re;
    logic [7:0]    mem_rdata = 8'h00;
    logic [7:0]    ram [256];

    int checks = 0;
    int errors = 0;

    dmem_port_arbiter #(.MEM_BYTES(256), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_valid(p0_valid), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ready(p0_ready), .p0_resp(p0_resp),
        .p1_valid(p1_valid), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ready(p1_ready), .p1_resp(p1_resp),
        .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        int          port;
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present a request and wait (bounded) for its handshake; returns just after the edge.
    task automatic issue(input int port, input bit write, input logic [31:0] addr,
                         input logic [31:0] wdata, output bit ok);
        @(negedge clk);
        if (port == 0) begin
            p0_valid = 1; p0_write = write; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_valid = 1; p1_write = write; p1_addr = addr; p1_wdata = wdata;
        end
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if ((port == 0 && p0_ready) || (port == 1 && p1_ready)) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("handshake_seen", {63'd0, ok}, 64'd1);
        @(posedge clk);
        #1;
        // Scramble the inputs: the transfer must use only the handshake-cycle values.
        p0_valid = 0; p1_valid = 0;
        p0_addr = 32'hFFFF_FFFF; p1_addr = 32'hFFFF_FFFF;
        p0_wdata = 32'h5555_5555; p1_wdata = 32'h5555_5555;
        p0_write = ~write; p1_write = ~write;
    endtask

    task automatic access(input int idx, input vec_t v);
        bit ok;
        logic [31:0] wd;
        logic [5:0]  wrd;
        logic [7:0]  bsel;
        logic [AW-1:0] eaddr;
        logic [19:0] exp_bus, act_bus;
        bit active, r0, r1;
        int resp_k;
        wd = v.wdata;
        wrd = v.addr[5:0];
        resp_k = v.write ? 5 : 6;
        issue(v.port, v.write, v.addr, v.wdata, ok);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            active = (k >= 1 && k <= 4);
            eaddr = active ? {wrd, 2'(k - 1)} : '0;
            case (k)
                1: bsel = wd[31:24];
                2: bsel = wd[23:16];
                3: bsel = wd[15:8];
                4: bsel = wd[7:0];
                default: bsel = 8'h00;
            endcase
            if (!v.write || !active) bsel = 8'h00;
            r0 = (k == resp_k) && (v.port == 0);
            r1 = (k == resp_k) && (v.port == 1);
            exp_bus = {active && v.write, active && !v.write, eaddr, bsel, r0, r1};
            act_bus = {mem_we, mem_re, mem_addr, mem_wdata, p0_resp, p1_resp};
            chk($sformatf("vec%0d_cyc%0d_bus", idx, k), {44'd0, act_bus}, {44'd0, exp_bus});
            if (k >= resp_k)
                chk($sformatf("vec%0d_cyc%0d_rdata", idx, k), {32'd0, resp_rdata}, {32'd0, v.exp_rdata});
        end
        $display("vec%0d port%0d %s addr=%h wdata=%h rdata=%h", idx, v.port,
                 v.write ? "store" : "load", v.addr, v.wdata, resp_rdata);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        bit ok;
        int gport [4];
        int gcyc  [4];
        int ng;
        for (int i = 0; i < 256; i++) ram[i] = 8'(i);

        vecs[0] = '{0, 1, 32'd5,          32'hDEADBEEF, 32'h00000000};
        vecs[1] = '{0, 0, 32'd5,          32'h0,        32'hDEADBEEF};
        vecs[2] = '{0, 1, 32'h41,         32'hA5A55A5A, 32'hDEADBEEF};
        vecs[3] = '{1, 0, 32'd1,          32'h0,        32'hA5A55A5A};
        vecs[4] = '{0, 0, 32'h10,         32'h0,        32'h40414243};
        vecs[5] = '{1, 1, 32'd7,          32'hCAFEF00D, 32'h40414243};
        vecs[6] = '{0, 0, 32'd7,          32'h0,        32'hCAFEF00D};
        vecs[7] = '{1, 1, 32'd8,          32'h12345678, 32'hCAFEF00D};
        vecs[8] = '{1, 0, 32'hFFFF_FF08,  32'h0,        32'h12345678};

        // Outputs held at zero in reset, even with a request pending.
        p0_valid = 1;
        #12;
        chk("reset_outputs",
            {20'd0, p0_ready, p1_ready, p0_resp, p1_resp, mem_we, mem_re, mem_addr, mem_wdata, resp_rdata},
            64'd0);
        p0_valid = 0;
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 9; i++) access(i, vecs[i]);

        // Contention from reset: strict alternation, one load each, 7 cycles apart.
        rst_n = 0;
        p0_valid = 1; p0_write = 0; p0_addr = 32'd5;
        p1_valid = 1; p1_write = 0; p1_addr = 32'd7;
        @(negedge clk);
        rst_n = 1;
        ng = 0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            #1;
            if (p0_ready && p1_ready) chk("dual_ready", 64'd1, 64'd0);
            if (p0_ready || p1_ready) begin
                gport[ng] = p1_ready ? 1 : 0;
                gcyc[ng]  = c;
                $display("grant %0d to port%0d at cycle %0d", ng, gport[ng], c);
                ng++;
            end
            @(negedge clk);
        end
        p0_valid = 0; p1_valid = 0;
        chk("tie_grant_count", 64'(ng), 64'd4);
        for (int g = 0; g < ng; g++) begin
            chk($sformatf("tie_grant%0d_port", g), 64'(gport[g]), 64'(g % 2));
            chk($sformatf("tie_grant%0d_cycle", g), 64'(gcyc[g] - gcyc[0]), 64'(7 * g));
        end
        repeat (10) @(negedge clk);

        // Port 1 alone, back-to-back loads: handshakes at 0, 7, 14.
        p1_valid = 1; p1_write = 0; p1_addr = 32'd5;
        ng = 0;
        for (int c = 0; c < 60 && ng < 3; c++) begin
            #1;
            if (p0_ready || p1_ready) begin
                gport[ng] = p1_ready ? 1 : 0;
                gcyc[ng]  = c;
                $display("solo grant %0d to port%0d at cycle %0d", ng, gport[ng], c);
                ng++;
            end
            @(negedge clk);
        end
        p1_valid = 0;
        chk("solo_grant_count", 64'(ng), 64'd3);
        for (int g = 0; g < ng; g++) begin
            chk($sformatf("solo_grant%0d_port", g), 64'(gport[g]), 64'd1);
            chk($sformatf("solo_grant%0d_cycle", g), 64'(gcyc[g] - gcyc[0]), 64'(7 * g));
        end
        repeat (10) @(negedge clk);

        // Reset at cnt = 2 of a store to word 0: only bytes 0 and 1 land.
        issue(0, 1, 32'd0, 32'h11223344, ok);
        repeat (2) @(posedge clk);
        #2;
        chk("abort_pre_state", {53'd0, mem_we, mem_re, mem_addr, 1'b0},
            {53'd0, 1'b1, 1'b0, 8'd2, 1'b0});
        rst_n = 0;
        #1;
        chk("abort_outputs_zero",
            {48'd0, p0_resp, p1_resp, mem_we, mem_re, mem_addr, mem_wdata, 4'd0}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("abort_no_resp_c%0d", c), {62'd0, p0_resp, p1_resp}, 64'd0);
        end
        vecs[0] = '{0, 0, 32'd0, 32'h0, 32'h11220203};
        access(9, vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
